uart_tx_serial: RTL and testbench
=================================

Name: uart_tx_serial

Overview:
8N1 (configurable stop bits) UART serializer directly downstream of the 32-bit-to-byte TX buffer. Accepts one byte per tstart/tready handshake and drives the serial line tx, LSB first, at a fixed baud derived from the system clock. Raises tready only when the line is idle and a new byte can be taken. Sits between the byte buffer and the FPGA TX pin.

Parameters:
CLK_FREQ, 65_000_000, system clock frequency in Hz
BAUD, 115_200, serial bit rate in bit/s
STOP_BITS, 1, number of stop bits (1 or 2; any other value treated as 1)
Derived, not overridable: CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD, rounded to nearest. Elaboration error if CLKS_PER_BIT < 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
tstart  input  1  byte-start request from TX buffer
tbus  input  8  byte to send; sampled only on accept cycle
tready  output  1  high = idle, next byte may be accepted
tx  output  1  serial line, idle high
busy  output  1  frame in progress (equals ~tready, registered)

Behaviour:
- Reset: rst high at rising edge forces state IDLE, tx=1, tready=1, busy=0, baud counter=0, bit index=0, shift register=0. Reset mid-frame aborts immediately; tx returns high on the next edge and no partial bits follow.
- Accept: on an edge where state=IDLE and tstart=1, latch tbus into the shift register, go to START, and clear the baud counter. At that same edge tready becomes 0 and tx becomes 0.
- tstart while not IDLE is ignored. The upstream buffer may hold tstart high for one extra cycle after accept; that cycle must not start a second frame.
- The baud counter counts 0..CLKS_PER_BIT-1. A bit ends on the cycle the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- States:
  - IDLE: tx=1, tready=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Timing, with accept at edge E: start bit spans E..E+CPB. Data bit i spans E+(1+i)*CPB..E+(2+i)*CPB. Stop spans E+9*CPB..E+(9+STOP_BITS)*CPB. tready returns to 1 at edge E+(9+STOP_BITS)*CPB.
- Back-to-back: if tstart=1 on the first cycle tready is high, the next frame is accepted at the following edge. The line is high for exactly 1 clock between the stop bit and the next start bit. No other gap is inserted.
- tx is driven from a register (glitch-free). All outputs are registered.
- tbus changes after accept have no effect on the frame in flight.

Test Plan:
- Reset idle: CLK_FREQ=1000, BAUD=100 (CPB=10). Hold rst 3 cycles then release, tstart=0 → tx=1, tready=1, busy=0 continuously for 200 cycles.
- Single byte: one accept with tbus=8'hA5 → tx sequence, each bit 10 cycles: 0,1,0,1,0,0,1,0,1,1. tready low for exactly 100 cycles and high at accept+100. Bench UART monitor decodes 8'hA5.
- Extended tstart: hold tstart high 2 cycles at accept with tbus=8'h3C, then change tbus to 8'hFF → exactly one frame, decoded 8'h3C. No second start bit within 101 cycles.
- Back-to-back: assert tstart whenever tready=1 with bytes 8'h00, 8'hFF, 8'h55 → three frames decoded in order. Each inter-frame idle-high gap is exactly 1 cycle.
- STOP_BITS=2, tbus=8'h81 → stop high 20 cycles. tready returns at accept+110. Decoded 8'h81.
- Mid-frame reset: accept 8'h0F, assert rst for 1 cycle at accept+35 (data bit 2) → tx=1 and tready=1 from the next edge. A fresh accept of 8'hF0 afterwards decodes correctly.

Source files
------------

// File: rtl/uart_tx_serial_if.sv
// Byte handshake and serial-line bundle between the TX byte buffer and the UART serializer.
interface uart_tx_serial_if;
  logic       tstart;
  logic [7:0] tbus;
  logic       tready;
  logic       tx;
  logic       busy;

  modport master (output tstart, output tbus, input tready, input tx, input busy);
  modport slave  (input tstart, input tbus, output tready, output tx, output busy);
endinterface

// File: rtl/uart_tx_serial.sv
// UART serializer: one byte per tstart/tready handshake, start bit, 8 data bits LSB first,
// 1 or 2 stop bits; every output comes straight from a register.
module uart_tx_serial #(
  parameter int CLK_FREQ  = 65_000_000,
  parameter int BAUD      = 115_200,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_serial_if.slave bus
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int STOP_N       = (STOP_BITS == 2) ? 2 : 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_serial: CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         idx, idx_n;
  logic [7:0]         shift, shift_n;
  logic               tx_q, tx_n;
  logic               tready_q, tready_n;
  logic               busy_q;
  logic               bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      tready_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
      tready_q <= tready_n;
      busy_q   <= ~tready_n;
    end
  end

  // Next-state logic also computes the next line level so tx is registered with no extra cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    tx_n     = tx_q;
    tready_n = tready_q;
    bit_end  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    unique case (state)
      IDLE: begin
        tx_n     = 1'b1;
        tready_n = 1'b1;
        if (bus.tstart) begin
          state_n  = START;
          shift_n  = bus.tbus;
          cnt_n    = '0;
          idx_n    = '0;
          tx_n     = 1'b0;
          tready_n = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shift[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (idx == 3'd7) begin
            state_n = STOP;
            idx_n   = '0;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
            tx_n  = shift[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'(STOP_N - 1)) begin
            state_n  = IDLE;
            idx_n    = '0;
            tready_n = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        tx_n     = 1'b1;
        tready_n = 1'b1;
      end
    endcase
  end

  assign bus.tx     = tx_q;
  assign bus.tready = tready_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serial.sv
// Directed and random frame checks of uart_tx_serial against a bit-period waveform model.
module tb_uart_tx_serial;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       start;
  logic [7:0] data;
  int         tests = 0;
  int         fails = 0;

  uart_tx_serial_if b1 ();
  uart_tx_serial_if b2 ();

  assign b1.tstart = start & ~sel;
  assign b2.tstart = start & sel;
  assign b1.tbus   = data;
  assign b2.tbus   = data;

  logic tx_s, tready_s, busy_s;
  assign tx_s     = sel ? b2.tx     : b1.tx;
  assign tready_s = sel ? b2.tready : b1.tready;
  assign busy_s   = sel ? b2.busy   : b1.busy;

  uart_tx_serial #(.CLK_FREQ(1000), .BAUD(100), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  uart_tx_serial #(.CLK_FREQ(1000), .BAUD(100), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level t cycles after the accept edge: bit slot k = t/CPB (0 start, 1..8 data, then stop/idle).
  function automatic logic exp_tx(input logic [7:0] b, input int t);
    int k;
    k = t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk({tag, "_tx"}, 8'(tx_s), 8'd1);
      chk({tag, "_tready"}, 8'(tready_s), 8'd1);
      chk({tag, "_busy"}, 8'(busy_s), 8'd0);
    end
  endtask

  // Caller has start=1 and data=b set; the accept happens at the next edge.
  task automatic run_frame(input logic [7:0] b, input int sb, input bit hold2, input int abort_at);
    int len;
    logic [7:0] dec;
    len = (9 + sb) * CPB;
    dec = '0;
    for (int t = 0; t <= len; t++) begin
      @(posedge clk); #1;
      if (abort_at != 0 && t == abort_at) begin
        chk("abort_tx", 8'(tx_s), 8'd1);
        chk("abort_tready", 8'(tready_s), 8'd1);
        chk("abort_busy", 8'(busy_s), 8'd0);
        rst = 1'b0;
        return;
      end
      if (t < len) begin
        chk("frame_tx", 8'(tx_s), 8'(exp_tx(b, t)));
        chk("frame_tready", 8'(tready_s), 8'd0);
        chk("frame_busy", 8'(busy_s), 8'd1);
      end else begin
        chk("end_tx", 8'(tx_s), 8'd1);
        chk("end_tready", 8'(tready_s), 8'd1);
        chk("end_busy", 8'(busy_s), 8'd0);
      end
      if (t >= CPB && t < 9 * CPB && (t % CPB) == CPB / 2) dec[t / CPB - 1] = tx_s;
      if (t == 0 && !hold2) begin
        start = 1'b0;
        data  = ~b;
      end
      if (t == 1 && hold2) begin
        start = 1'b0;
        data  = 8'hFF;
      end
      if (abort_at != 0 && t == abort_at - 1) rst = 1'b1;
    end
    chk("decoded", dec, b);
  endtask

  initial begin
    logic [7:0] rb;
    sel   = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 8'(tx_s), 8'd1);
    chk("reset_tready", 8'(tready_s), 8'd1);
    chk("reset_busy", 8'(busy_s), 8'd0);
    rst = 1'b0;
    idle_cycles(200, "idle");

    start = 1'b1; data = 8'hA5;
    run_frame(8'hA5, 1, 1'b0, 0);

    start = 1'b1; data = 8'h3C;
    run_frame(8'h3C, 1, 1'b1, 0);
    idle_cycles(10, "no_second");

    start = 1'b1; data = 8'h00;
    run_frame(8'h00, 1, 1'b0, 0);
    start = 1'b1; data = 8'hFF;
    run_frame(8'hFF, 1, 1'b0, 0);
    start = 1'b1; data = 8'h55;
    run_frame(8'h55, 1, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      idle_cycles(int'($urandom_range(0, 3)), "rand_gap");
      rb = 8'($urandom);
      start = 1'b1; data = rb;
      run_frame(rb, 1, 1'b0, 0);
    end

    sel = 1'b1;
    start = 1'b1; data = 8'h81;
    run_frame(8'h81, 2, 1'b0, 0);
    sel = 1'b0;

    start = 1'b1; data = 8'h0F;
    run_frame(8'h0F, 1, 1'b0, 35);
    idle_cycles(5, "post_abort");
    start = 1'b1; data = 8'hF0;
    run_frame(8'hF0, 1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
